// File: rtl/pass_sequencer_pkg.sv
// dt_pkg: shared definitions for the distance-transform pass sequencer.
//   DT_ADDR_W / DT_DATA_W : image memory address and pixel widths (128x128, 8-bit)
//   DT_TIMEOUT            : default per-pass cycle limit
//   seq_state_t           : sequencer state encoding
//   rounds_of()           : maps the iter request to a round count (0 runs once)
package dt_pkg;

  localparam int          DT_ADDR_W  = 14;
  localparam int          DT_DATA_W  = 8;
  localparam logic [19:0] DT_TIMEOUT = 20'd65535;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_FWD  = 3'd2,
    ST_GAP  = 3'd3,
    ST_BWD  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } seq_state_t;

  function automatic logic [2:0] rounds_of(input logic [2:0] iter);
    return (iter == 3'd0) ? 3'd1 : iter;
  endfunction

endpackage

// File: rtl/pass_sequencer_if.sv
// pass_sequencer_if: bundle between the sequencer, the two pass engines and the
// shared image memory.
//   eng_clr, f_en, b_en          : sequencer -> engines
//   f_done/f_rd/f_wr/f_addr/f_do : forward engine -> sequencer
//   b_done/b_rd/b_wr/b_addr/b_do : backward engine -> sequencer
//   mem_rd/mem_wr/mem_addr/mem_d : sequencer -> shared memory
// master = sequencer side, slave = engine/memory side.
interface pass_sequencer_if import dt_pkg::*; #(
  parameter int ADDR_W = DT_ADDR_W,
  parameter int DATA_W = DT_DATA_W
) ();

  logic              eng_clr;
  logic              f_en;
  logic              f_done;
  logic              f_rd;
  logic              f_wr;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_do;
  logic              b_en;
  logic              b_done;
  logic              b_rd;
  logic              b_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_do;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_d;

  modport master (
    output eng_clr, f_en, b_en, mem_rd, mem_wr, mem_addr, mem_d,
    input  f_done, f_rd, f_wr, f_addr, f_do,
    input  b_done, b_rd, b_wr, b_addr, b_do
  );

  modport slave (
    input  eng_clr, f_en, b_en, mem_rd, mem_wr, mem_addr, mem_d,
    output f_done, f_rd, f_wr, f_addr, f_do,
    output b_done, b_rd, b_wr, b_addr, b_do
  );

endinterface

// File: rtl/pass_sequencer_mem_port_mux.sv
// mem_port_mux: combinational owner select for the shared image memory port.
//   i_sel_f / i_sel_b : forward / backward engine owns the port (never both)
//   i_f_* / i_b_*     : engine strobes, address and write data
//   o_mem_*           : shared memory strobes, address and write data
// With no owner every output is zero, so an idle engine can never leak a strobe.
module mem_port_mux import dt_pkg::*; #(
  parameter int ADDR_W = DT_ADDR_W,
  parameter int DATA_W = DT_DATA_W
) (
  input  logic              i_sel_f,
  input  logic              i_sel_b,
  input  logic              i_f_rd,
  input  logic              i_f_wr,
  input  logic [ADDR_W-1:0] i_f_addr,
  input  logic [DATA_W-1:0] i_f_do,
  input  logic              i_b_rd,
  input  logic              i_b_wr,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_do,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_d
);

  always_comb begin
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_mem_addr = '0;
    o_mem_d    = '0;
    if (i_sel_f) begin
      o_mem_rd   = i_f_rd;
      o_mem_wr   = i_f_wr;
      o_mem_addr = i_f_addr;
      o_mem_d    = i_f_do;
    end else if (i_sel_b) begin
      o_mem_rd   = i_b_rd;
      o_mem_wr   = i_b_wr;
      o_mem_addr = i_b_addr;
      o_mem_d    = i_b_do;
    end
  end

endmodule

// File: rtl/pass_sequencer.sv
// pass_sequencer: runs a distance-transform job as iter rounds of
// forward pass -> one idle cycle -> backward pass, with a per-pass watchdog.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   i_start, i_iter : job request and round count (accepted in IDLE/DONE/ERR)
//   o_busy          : job in progress
//   o_done          : job finished, held until the next accepted start
//   o_timeout_err   : a pass overran TIMEOUT, held until the next accepted start
//   bus             : engine control/status and shared memory port (master)
//
// state | meaning
// IDLE  | waiting for start after reset
// CLR   | one-cycle eng_clr pulse at the top of each round
// FWD   | forward engine owns memory until f_done
// GAP   | one dead cycle between passes, memory port quiet
// BWD   | backward engine owns memory until b_done
// DONE  | all rounds complete, waiting for start
// ERR   | a pass timed out, waiting for start
module pass_sequencer import dt_pkg::*; #(
  parameter int          ADDR_W  = DT_ADDR_W,
  parameter int          DATA_W  = DT_DATA_W,
  parameter logic [19:0] TIMEOUT = DT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [2:0]       i_iter,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout_err,
  pass_sequencer_if.master bus
);

  // Down-counter: loaded on pass entry so the TIMEOUT-th cycle of a pass hits zero.
  localparam logic [19:0] CYC_LOAD = TIMEOUT - 20'd1;

  seq_state_t  r_state;
  seq_state_t  w_next;
  logic [19:0] r_cyc;
  logic [2:0]  r_rounds;
  logic        w_tc;
  logic        w_start_ok;
  logic        w_enter_pass;
  logic        w_sel_f;
  logic        w_sel_b;

  assign w_tc         = (r_cyc == 20'd0);
  assign w_start_ok   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                    (r_state == ST_ERR));
  assign w_enter_pass = ((w_next == ST_FWD) && (r_state != ST_FWD)) ||
                        ((w_next == ST_BWD) && (r_state != ST_BWD));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Engine done is checked before the watchdog so a done on the last allowed cycle wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (i_start) w_next = ST_CLR;
      ST_CLR: w_next = ST_FWD;
      ST_FWD: begin
        if (bus.f_done) w_next = ST_GAP;
        else if (w_tc)  w_next = ST_ERR;
      end
      ST_GAP: w_next = ST_BWD;
      ST_BWD: begin
        if (bus.b_done) w_next = (r_rounds <= 3'd1) ? ST_DONE : ST_CLR;
        else if (w_tc)  w_next = ST_ERR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc    <= 20'd0;
      r_rounds <= 3'd0;
    end else begin
      if (w_enter_pass)
        r_cyc <= CYC_LOAD;
      else if (((r_state == ST_FWD) || (r_state == ST_BWD)) && !w_tc)
        r_cyc <= r_cyc - 20'd1;

      if (w_start_ok)
        r_rounds <= rounds_of(i_iter);
      else if ((r_state == ST_BWD) && bus.b_done)
        r_rounds <= r_rounds - 3'd1;
    end
  end

  always_comb begin
    o_busy        = 1'b0;
    o_done        = 1'b0;
    o_timeout_err = 1'b0;
    bus.eng_clr   = 1'b0;
    w_sel_f       = 1'b0;
    w_sel_b       = 1'b0;
    case (r_state)
      ST_CLR: begin
        o_busy      = 1'b1;
        bus.eng_clr = 1'b1;
      end
      ST_FWD: begin
        o_busy  = 1'b1;
        w_sel_f = 1'b1;
      end
      ST_GAP:  o_busy        = 1'b1;
      ST_BWD: begin
        o_busy  = 1'b1;
        w_sel_b = 1'b1;
      end
      ST_DONE: o_done        = 1'b1;
      ST_ERR:  o_timeout_err = 1'b1;
      default: ;
    endcase
  end

  assign bus.f_en = w_sel_f;
  assign bus.b_en = w_sel_b;

  mem_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_port_mux (
    .i_sel_f    (w_sel_f),
    .i_sel_b    (w_sel_b),
    .i_f_rd     (bus.f_rd),
    .i_f_wr     (bus.f_wr),
    .i_f_addr   (bus.f_addr),
    .i_f_do     (bus.f_do),
    .i_b_rd     (bus.b_rd),
    .i_b_wr     (bus.b_wr),
    .i_b_addr   (bus.b_addr),
    .i_b_do     (bus.b_do),
    .o_mem_rd   (bus.mem_rd),
    .o_mem_wr   (bus.mem_wr),
    .o_mem_addr (bus.mem_addr),
    .o_mem_d    (bus.mem_d)
  );

endmodule

// File: tb/tb_pass_sequencer.sv
// Testbench for pass_sequencer: behavioural forward/backward engines with
// programmable done latency, a scoreboard of expected enable-run lengths, and
// per-scenario tasks.
module tb_pass_sequencer;

  localparam int          TMO      = 100;
  localparam logic [13:0] B_PROBE  = 14'd16255;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic [2:0] i_iter;
  logic       o_busy;
  logic       o_done;
  logic       o_timeout_err;

  pass_sequencer_if #(.ADDR_W(14), .DATA_W(8)) bus ();

  pass_sequencer #(
    .ADDR_W  (14),
    .DATA_W  (8),
    .TIMEOUT (20'd100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_iter        (i_iter),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_timeout_err (o_timeout_err),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int f_lat = 0;
  int b_lat = 0;
  bit b_force = 1'b0;
  bit sb_on   = 1'b1;
  int fcnt = 0, bcnt = 0;
  int f_run = 0, b_run = 0;
  int clr_cnt = 0, gap_cnt = 0, mux_viol = 0;
  int exp_f[$];
  int exp_b[$];
  int exp_val;
  logic [23:0] mux_exp;
  logic [31:0] out_vec;

  // Monitor + engine models + strobe generator, all at the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.f_en)      mux_exp = {bus.f_rd, bus.f_wr, bus.f_addr, bus.f_do};
      else if (bus.b_en) mux_exp = {bus.b_rd, bus.b_wr, bus.b_addr, bus.b_do};
      else               mux_exp = 24'd0;
      n_checks++;
      if ({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_d} !== mux_exp)
        $display("FAIL mem_mux got=%h want=%h f_en=%b b_en=%b", 
                 {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_d}, mux_exp, bus.f_en, bus.b_en);
      else n_pass++;

      if (b_force && bus.f_en &&
          ((bus.mem_rd !== bus.f_rd) || (bus.mem_addr === B_PROBE)))
        mux_viol++;
      if (bus.eng_clr) clr_cnt++;
      if (o_busy && !bus.f_en && !bus.b_en && !bus.eng_clr) gap_cnt++;

      if (bus.f_en) f_run++;
      else if (f_run > 0) begin
        if (sb_on) begin
          n_checks++;
          if (exp_f.size() == 0)
            $display("FAIL f_run unexpected got=%0d want=none", f_run);
          else begin
            exp_val = exp_f.pop_front();
            if (f_run !== exp_val) $display("FAIL f_run_len got=%0d want=%0d", f_run, exp_val);
            else n_pass++;
          end
        end
        f_run = 0;
      end

      if (bus.b_en) b_run++;
      else if (b_run > 0) begin
        if (sb_on) begin
          n_checks++;
          if (exp_b.size() == 0)
            $display("FAIL b_run unexpected got=%0d want=none", b_run);
          else begin
            exp_val = exp_b.pop_front();
            if (b_run !== exp_val) $display("FAIL b_run_len got=%0d want=%0d", b_run, exp_val);
            else n_pass++;
          end
        end
        b_run = 0;
      end
    end else begin
      f_run = 0;
      b_run = 0;
    end

    if (reset || bus.eng_clr) begin
      fcnt = 0; bcnt = 0;
      bus.f_done = 1'b0;
      bus.b_done = 1'b0;
    end else begin
      if (bus.f_en && !bus.f_done) begin
        fcnt++;
        if (f_lat != 0 && fcnt == f_lat) bus.f_done = 1'b1;
      end
      if (bus.b_en && !bus.b_done) begin
        bcnt++;
        if (b_lat != 0 && bcnt == b_lat) bus.b_done = 1'b1;
      end
    end

    bus.f_rd   = 1'($urandom_range(0, 1));
    bus.f_wr   = 1'($urandom_range(0, 1));
    bus.f_addr = 14'($urandom_range(0, 16254));
    bus.f_do   = 8'($urandom_range(0, 255));
    if (b_force) begin
      bus.b_rd   = 1'b1;
      bus.b_wr   = 1'b0;
      bus.b_addr = B_PROBE;
    end else begin
      bus.b_rd   = 1'($urandom_range(0, 1));
      bus.b_wr   = 1'($urandom_range(0, 1));
      bus.b_addr = 14'($urandom_range(0, 16383));
    end
    bus.b_do = 8'($urandom_range(0, 255));
  end

  task automatic start_job(input logic [2:0] it);
    @(negedge clk);
    i_start = 1'b1;
    i_iter  = it;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_finish(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (o_done || o_timeout_err) break;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_vec = {o_busy, o_done, o_timeout_err, bus.eng_clr, bus.f_en, bus.b_en,
               bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_d};
    n_checks++;
    if (out_vec !== 32'd0) $display("FAIL reset_outputs got=%h want=0", out_vec);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", o_busy);
    else n_pass++;
  endtask

  task automatic test_single;
    f_lat = 20; b_lat = 40;
    exp_f.push_back(20); exp_b.push_back(40);
    clr_cnt = 0; gap_cnt = 0;
    start_job(3'd1);
    n_checks++;
    if ({o_busy, bus.eng_clr, o_done} !== 3'b110)
      $display("FAIL single_start got=%b want=110", {o_busy, bus.eng_clr, o_done});
    else n_pass++;
    wait_finish(200);
    n_checks++;
    if ({o_done, o_busy, o_timeout_err} !== 3'b100)
      $display("FAIL single_done got=%b want=100", {o_done, o_busy, o_timeout_err});
    else n_pass++;
    n_checks++;
    if (clr_cnt !== 1) $display("FAIL single_clr got=%0d want=1", clr_cnt);
    else n_pass++;
    n_checks++;
    if (gap_cnt !== 1) $display("FAIL single_gap got=%0d want=1", gap_cnt);
    else n_pass++;
    n_checks++;
    if (exp_f.size() + exp_b.size() !== 0)
      $display("FAIL single_sb_left got=%0d want=0", exp_f.size() + exp_b.size());
    else n_pass++;
  endtask

  task automatic test_multi;
    f_lat = 7; b_lat = 11;
    for (int r = 0; r < 3; r++) begin
      exp_f.push_back(7);
      exp_b.push_back(11);
    end
    clr_cnt = 0; gap_cnt = 0;
    start_job(3'd3);
    n_checks++;
    if (o_done !== 1'b0) $display("FAIL multi_done_cleared got=%b want=0", o_done);
    else n_pass++;
    wait_finish(400);
    n_checks++;
    if (o_done !== 1'b1) $display("FAIL multi_done got=%b want=1", o_done);
    else n_pass++;
    n_checks++;
    if (clr_cnt !== 3) $display("FAIL multi_clr got=%0d want=3", clr_cnt);
    else n_pass++;
    n_checks++;
    if (gap_cnt !== 3) $display("FAIL multi_gap got=%0d want=3", gap_cnt);
    else n_pass++;
    n_checks++;
    if (exp_f.size() + exp_b.size() !== 0)
      $display("FAIL multi_sb_left got=%0d want=0", exp_f.size() + exp_b.size());
    else n_pass++;
  endtask

  task automatic test_iter0;
    f_lat = 3; b_lat = 2;
    exp_f.push_back(3); exp_b.push_back(2);
    clr_cnt = 0;
    start_job(3'd0);
    wait_finish(100);
    n_checks++;
    if ({o_done, clr_cnt[1:0]} !== 3'b101)
      $display("FAIL iter0 got done=%b clr=%0d want done=1 clr=1", o_done, clr_cnt);
    else n_pass++;
    n_checks++;
    if (exp_f.size() + exp_b.size() !== 0)
      $display("FAIL iter0_sb_left got=%0d want=0", exp_f.size() + exp_b.size());
    else n_pass++;
  endtask

  task automatic test_timeout;
    f_lat = 0; b_lat = 5;
    exp_f.push_back(TMO);
    clr_cnt = 0; gap_cnt = 0;
    start_job(3'd2);
    wait_finish(300);
    n_checks++;
    if ({o_timeout_err, o_done, o_busy} !== 3'b100)
      $display("FAIL timeout_flags got=%b want=100", {o_timeout_err, o_done, o_busy});
    else n_pass++;
    n_checks++;
    if ({bus.f_en, bus.b_en, bus.mem_rd, bus.mem_wr} !== 4'b0000)
      $display("FAIL timeout_quiet got=%b want=0000", {bus.f_en, bus.b_en, bus.mem_rd, bus.mem_wr});
    else n_pass++;
    n_checks++;
    if ({gap_cnt, exp_f.size()} !== {32'd0, 32'd0})
      $display("FAIL timeout_gap_sb got gap=%0d left=%0d want 0 0", gap_cnt, exp_f.size());
    else n_pass++;
  endtask

  task automatic test_coincide;
    f_lat = TMO; b_lat = 4;
    exp_f.push_back(TMO); exp_b.push_back(4);
    start_job(3'd1);
    n_checks++;
    if ({o_busy, o_timeout_err} !== 2'b10)
      $display("FAIL err_cleared got=%b want=10", {o_busy, o_timeout_err});
    else n_pass++;
    wait_finish(300);
    n_checks++;
    if ({o_done, o_timeout_err} !== 2'b10)
      $display("FAIL coincide got=%b want=10", {o_done, o_timeout_err});
    else n_pass++;
    n_checks++;
    if (exp_f.size() + exp_b.size() !== 0)
      $display("FAIL coincide_sb_left got=%0d want=0", exp_f.size() + exp_b.size());
    else n_pass++;
  endtask

  task automatic test_mux_isolation;
    f_lat = 30; b_lat = 5;
    exp_f.push_back(30); exp_b.push_back(5);
    mux_viol = 0;
    b_force = 1'b1;
    start_job(3'd1);
    wait_finish(200);
    b_force = 1'b0;
    n_checks++;
    if (mux_viol !== 0) $display("FAIL b_leak got=%0d want=0", mux_viol);
    else n_pass++;
    n_checks++;
    if (o_done !== 1'b1) $display("FAIL mux_job_done got=%b want=1", o_done);
    else n_pass++;
  endtask

  task automatic test_start_ignored;
    f_lat = 15; b_lat = 15;
    exp_f.push_back(15); exp_b.push_back(15);
    clr_cnt = 0;
    start_job(3'd1);
    repeat (5) @(negedge clk);
    i_start = 1'b1;
    i_iter  = 3'd2;
    repeat (3) @(negedge clk);
    i_start = 1'b0;
    wait_finish(200);
    n_checks++;
    if ({o_done, clr_cnt[1:0]} !== 3'b101)
      $display("FAIL start_ignored got done=%b clr=%0d want done=1 clr=1", o_done, clr_cnt);
    else n_pass++;
    n_checks++;
    if (exp_f.size() + exp_b.size() !== 0)
      $display("FAIL ignored_sb_left got=%0d want=0", exp_f.size() + exp_b.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_bwd;
    sb_on = 1'b0;
    f_lat = 4; b_lat = 50;
    start_job(3'd2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.b_en) break;
    end
    n_checks++;
    if (bus.b_en !== 1'b1) $display("FAIL reached_bwd got=%b want=1", bus.b_en);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset   = 1'b1;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    out_vec = {o_busy, o_done, o_timeout_err, bus.eng_clr, bus.f_en, bus.b_en,
               bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_d};
    n_checks++;
    if (out_vec !== 32'd0) $display("FAIL midbwd_reset got=%h want=0", out_vec);
    else n_pass++;
    @(negedge clk);
    reset   = 1'b0;
    i_start = 1'b0;
    clr_cnt = 0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({o_busy, o_done, clr_cnt[1:0]} !== 4'b0000)
      $display("FAIL post_reset_idle got busy=%b done=%b clr=%0d want 0 0 0", o_busy, o_done, clr_cnt);
    else n_pass++;
    sb_on = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    i_start = 1'b0;
    i_iter  = 3'd0;
    test_reset;
    test_single;
    test_multi;
    test_iter0;
    test_timeout;
    test_coincide;
    test_mux_isolation;
    test_start_ignored;
    test_reset_mid_bwd;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pass_sequencer.md
PASS_SEQUENCER -- requirements
Module: pass_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, 14, image memory address width (128x128 pixels).
REQ-002 SHALL have parameter DATA_W, 8, pixel width.
REQ-003 SHALL have parameter TIMEOUT, 20'd65535, maximum cycles per pass before error.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to run a distance-transform job; sampled only in IDLE, DONE or ERR.
REQ-007 SHALL have port iter  input  3  number of forward+backward rounds, latched on accepted start; 0 is treated as 1.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until DONE or ERR.
REQ-009 SHALL have port done  output  1  job complete, held until next accepted start.
REQ-010 SHALL have port timeout_err  output  1  pass exceeded TIMEOUT, held until next accepted start.
REQ-011 SHALL have port eng_clr  output  1  one-cycle pulse clearing both pass engines.
REQ-012 SHALL have port f_en  output  1  forward engine enable (level).
REQ-013 SHALL have port f_done  input  1  forward engine done (sticky until eng_clr).
REQ-014 SHALL have port f_rd, f_wr  input  1 each  forward engine memory strobes.
REQ-015 SHALL have port f_addr / f_do  input  ADDR_W / DATA_W  forward engine address / write data.
REQ-016 SHALL have port b_en  output  1  backward engine enable (level).
REQ-017 SHALL have port b_done  input  1  backward engine done (sticky until eng_clr).
REQ-018 SHALL have port b_rd, b_wr  input  1 each  backward engine memory strobes.
REQ-019 SHALL have port b_addr / b_do  input  ADDR_W / DATA_W  backward engine address / write data.
REQ-020 SHALL have port mem_rd, mem_wr  output  1 each  shared image memory strobes.
REQ-021 SHALL have port mem_addr / mem_d  output  ADDR_W / DATA_W  shared memory address / write data.

Function
REQ-022 SHALL implement states IDLE, CLR, FWD, GAP, BWD, DONE, ERR in a registered FSM.
REQ-023 SHALL, on start=1 in IDLE/DONE/ERR, go to CLR next cycle, latch iter, clear done and timeout_err; start is ignored in all other states.
REQ-024 SHALL assert eng_clr only in CLR (one cycle), then go to FWD.
REQ-025 SHALL assert f_en only in FWD; leave FWD for GAP in the cycle after f_done=1 is sampled.
REQ-026 SHALL spend exactly one cycle in GAP with both enables low and no memory strobes, then go to BWD.
REQ-027 SHALL assert b_en only in BWD; on b_done=1, decrement the round counter and go to CLR if rounds remain, else DONE.
REQ-028 SHALL drive mem_* combinationally from f_* in FWD, from b_* in BWD, and all-zero in every other state; both strobes never high from different engines in the same cycle.
REQ-029 SHALL reset a 20-bit cycle counter on entry to FWD/BWD; if it reaches TIMEOUT before done, go to ERR with timeout_err=1, enables low.
REQ-030 SHALL, if f_done and a timeout coincide, honour done (no error).
REQ-031 SHALL hold DONE/ERR until start; done=1 in DONE, busy=0 in IDLE/DONE/ERR.

Reset
REQ-032 SHALL, on reset=1 at any state including mid-pass, enter IDLE next edge with busy, done, timeout_err, eng_clr, f_en, b_en, mem_rd, mem_wr = 0, mem_addr/mem_d = 0, counters 0.

Structure
REQ-033 SHALL take state encodings, ADDR_W, DATA_W and TIMEOUT default from shared package dt_pkg.
REQ-034 SHALL place the memory mux in sub-module mem_port_mux; FSM and counters stay in pass_sequencer.

Verification
REQ-035 iter=1, start; f_done at cycle 20, b_done at cycle 40 after that -> eng_clr once, f_en 20 cycles, one GAP cycle, then done=1.
REQ-036 iter=3 -> eng_clr pulses exactly 3 times, f_en/b_en alternate 3 times, done after third b_done.
REQ-037 TIMEOUT=100, f_done never asserted -> timeout_err=1 at cycle 100 of FWD, f_en=0, mem_rd=mem_wr=0.
REQ-038 b_rd=1, b_addr=16255 during FWD -> mem_rd follows f_rd only; b request not visible.
REQ-039 reset=1 during BWD -> next cycle IDLE, all outputs 0; start ignored while busy=1.
